// File: rtl/aoc5_range_parser.sv
// aoc5_range_parser: decodes "start-end" ASCII lines into range tuples and
// packs two tuples per ping-bank row. A blank line or eof_in flushes a
// half-filled row with an all-ones pad tuple and then pulses stream_done_out.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif

module aoc5_range_parser #(
  parameter int unsigned VAL_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = `BANK_ADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             char_in,
  input  logic                   char_valid_in,
  output logic                   char_ready_out,
  input  logic                   eof_in,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [2*VAL_WIDTH-1:0] even_data_out,
  output logic [2*VAL_WIDTH-1:0] odd_data_out,
  output logic                   data_valid_out,
  output logic                   stream_done_out,
  output logic [31:0]            tuple_count_out,
  output logic                   parse_error_out
);

  typedef enum logic [2:0] {S_START, S_END, S_SKIP, S_FLUSH, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [VAL_WIDTH-1:0]   acc_q, acc_d;
  logic [VAL_WIDTH-1:0]   start_q, start_d;
  logic                   digit_seen_q, digit_seen_d;
  logic [2*VAL_WIDTH-1:0] slot_q, slot_d;
  logic                   slot_full_q, slot_full_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [2*VAL_WIDTH-1:0] even_q, even_d;
  logic [2*VAL_WIDTH-1:0] odd_q, odd_d;
  logic                   dv_q, dv_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [31:0]            count_q, count_d;

  logic                   accept;
  logic                   is_digit, is_dash, is_nl, is_cr;
  logic [3:0]             digit;
  logic [VAL_WIDTH-1:0]   acc_next;
  logic [VAL_WIDTH-1:0]   lo, hi;
  logic                   tuple_done, flush_req;

  assign char_ready_out  = (state_q == S_START) || (state_q == S_END) || (state_q == S_SKIP);
  assign accept          = char_valid_in && char_ready_out;
  assign is_digit        = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_dash         = (char_in == 8'h2d);
  assign is_nl           = (char_in == 8'h0a);
  assign is_cr           = (char_in == 8'h0d);
  assign digit           = char_in[3:0];
  assign acc_next        = (acc_q << 3) + (acc_q << 1) + VAL_WIDTH'(digit);
  assign lo              = (start_q > acc_q) ? acc_q : start_q;
  assign hi              = (start_q > acc_q) ? start_q : acc_q;

  assign addr_out        = addr_q;
  assign even_data_out   = even_q;
  assign odd_data_out    = odd_q;
  assign data_valid_out  = dv_q;
  assign stream_done_out = done_q;
  assign tuple_count_out = count_q;
  assign parse_error_out = err_q;

  // Next-state: byte decode, row packing, eof handling and flush sequencing.
  // The byte is applied first and eof then acts on the post-byte context, so a
  // tuple completed together with eof is kept before flushing.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    start_d      = start_q;
    digit_seen_d = digit_seen_q;
    slot_d       = slot_q;
    slot_full_d  = slot_full_q;
    addr_d       = addr_q + ADDR_WIDTH'(dv_q);
    even_d       = even_q;
    odd_d        = odd_q;
    dv_d         = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    count_d      = count_q;
    tuple_done   = 1'b0;
    flush_req    = 1'b0;

    if (accept && !is_cr) begin
      case (state_q)
        S_START: begin
          if (is_digit) begin
            acc_d        = acc_next;
            digit_seen_d = 1'b1;
          end else if (is_dash && digit_seen_q) begin
            start_d      = acc_q;
            acc_d        = '0;
            digit_seen_d = 1'b0;
            state_d      = S_END;
          end else if (is_nl && !digit_seen_q) begin
            flush_req    = 1'b1;
          end else begin
            err_d        = 1'b1;
            acc_d        = '0;
            digit_seen_d = 1'b0;
            state_d      = is_nl ? S_START : S_SKIP;
          end
        end
        S_END: begin
          if (is_digit) begin
            acc_d        = acc_next;
            digit_seen_d = 1'b1;
          end else if (is_nl && digit_seen_q) begin
            tuple_done   = 1'b1;
            acc_d        = '0;
            digit_seen_d = 1'b0;
            state_d      = S_START;
          end else begin
            err_d        = 1'b1;
            acc_d        = '0;
            digit_seen_d = 1'b0;
            state_d      = is_nl ? S_START : S_SKIP;
          end
        end
        S_SKIP: begin
          if (is_nl) state_d = S_START;
        end
        default: ;
      endcase
    end

    if (tuple_done) begin
      count_d = count_q + 32'd1;
      if (!slot_full_q) begin
        slot_d      = {lo, hi};
        slot_full_d = 1'b1;
      end else begin
        even_d      = slot_q;
        odd_d       = {lo, hi};
        dv_d        = 1'b1;
        slot_full_d = 1'b0;
      end
    end

    if (eof_in && char_ready_out) begin
      if (digit_seen_d || (state_d == S_END)) err_d = 1'b1;
      acc_d        = '0;
      digit_seen_d = 1'b0;
      flush_req    = 1'b1;
    end

    if (flush_req) begin
      if (slot_full_d || dv_d) begin
        state_d = S_FLUSH;
      end else begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
    end

    if (state_q == S_FLUSH) begin
      if (slot_full_q) begin
        even_d      = slot_q;
        odd_d       = '1;
        dv_d        = 1'b1;
        slot_full_d = 1'b0;
      end else begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_START;
      acc_q        <= '0;
      start_q      <= '0;
      digit_seen_q <= 1'b0;
      slot_q       <= '0;
      slot_full_q  <= 1'b0;
      addr_q       <= '0;
      even_q       <= '0;
      odd_q        <= '0;
      dv_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      start_q      <= start_d;
      digit_seen_q <= digit_seen_d;
      slot_q       <= slot_d;
      slot_full_q  <= slot_full_d;
      addr_q       <= addr_d;
      even_q       <= even_d;
      odd_q        <= odd_d;
      dv_q         <= dv_d;
      done_q       <= done_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_aoc5_range_parser.sv
`timescale 1ns/1ps
module tb_aoc5_range_parser;
  localparam int unsigned VW = 64;
  localparam int unsigned AW = 3;
  typedef logic [7:0] u8;
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*VW-1:0] even;
    logic [2*VW-1:0] odd;
  } row_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      char_in = '0;
  logic            char_valid_in = 1'b0;
  logic            eof_in = 1'b0;
  logic            char_ready_out;
  logic [AW-1:0]   addr_out;
  logic [2*VW-1:0] even_data_out;
  logic [2*VW-1:0] odd_data_out;
  logic            data_valid_out;
  logic            stream_done_out;
  logic [31:0]     tuple_count_out;
  logic            parse_error_out;

  aoc5_range_parser #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .char_in         (char_in),
    .char_valid_in   (char_valid_in),
    .char_ready_out  (char_ready_out),
    .eof_in          (eof_in),
    .addr_out        (addr_out),
    .even_data_out   (even_data_out),
    .odd_data_out    (odd_data_out),
    .data_valid_out  (data_valid_out),
    .stream_done_out (stream_done_out),
    .tuple_count_out (tuple_count_out),
    .parse_error_out (parse_error_out)
  );

  always #5 clock = ~clock;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   trig_cyc  = -1;
  int   last_dv   = -1;
  int   done_cnt  = 0;
  int   exp_count = 0;
  logic exp_err   = 1'b0;
  row_t exp_q[$];
  u8    gen_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_addr",  128'(addr_out), 128'(0));
    check("rst_even",  even_data_out, 128'(0));
    check("rst_odd",   odd_data_out, 128'(0));
    check("rst_valid", 128'(data_valid_out), 128'(0));
    check("rst_done",  128'(stream_done_out), 128'(0));
    check("rst_count", 128'(tuple_count_out), 128'(0));
    check("rst_error", 128'(parse_error_out), 128'(0));
    check("rst_ready", 128'(char_ready_out), 128'(1));
  endtask

  // ---------------- reference model (line oriented) ----------------
  task automatic parse_line(input u8 l[$], output bit ok, output logic [127:0] t);
    int dash, ndash;
    logic [63:0] s, e;
    ok = 1'b1; dash = -1; ndash = 0; s = '0; e = '0;
    for (int i = 0; i < l.size(); i++) begin
      if (l[i] == 8'h2d) begin ndash++; dash = i; end
      else if (l[i] < 8'h30 || l[i] > 8'h39) ok = 1'b0;
    end
    if (ndash != 1 || dash == 0 || dash == l.size() - 1) ok = 1'b0;
    if (ok) begin
      for (int i = 0; i < dash; i++) s = s * 10 + 64'(l[i] - 8'h30);
      for (int i = dash + 1; i < l.size(); i++) e = e * 10 + 64'(l[i] - 8'h30);
    end
    t = (s > e) ? {e, s} : {s, e};
  endtask

  task automatic model(input bit eof, output int term_idx);
    u8 line[$];
    logic [127:0] tups[$];
    logic [127:0] t;
    bit ok, err, terminated;
    row_t r;
    err = 1'b0; terminated = 1'b0; term_idx = -1;
    for (int i = 0; i < gen_q.size(); i++) begin
      if (gen_q[i] == 8'h0d) continue;
      if (gen_q[i] == 8'h0a) begin
        if (line.size() == 0) begin terminated = 1'b1; term_idx = i; break; end
        parse_line(line, ok, t);
        if (ok) tups.push_back(t); else err = 1'b1;
        line.delete();
      end else begin
        line.push_back(gen_q[i]);
      end
    end
    if (!terminated && eof) begin
      if (line.size() > 0) err = 1'b1;
      terminated = 1'b1;
    end
    for (int k = 0; k < tups.size(); k += 2) begin
      r.addr = AW'(k / 2);
      r.even = tups[k];
      if (k + 1 < tups.size()) begin
        r.odd = tups[k+1];
        exp_q.push_back(r);
      end else if (terminated) begin
        r.odd = '1;
        exp_q.push_back(r);
      end
    end
    exp_count = tups.size();
    exp_err   = err;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic void add_str(input string s);
    for (int i = 0; i < s.len(); i++) gen_q.push_back(u8'(s[i]));
  endfunction

  function automatic void push_dec(input logic [63:0] v);
    u8 tmp[$];
    if (v == 0) tmp.push_front(8'h30);
    while (v != 0) begin
      tmp.push_front(8'h30 + 8'(v % 10));
      v = v / 10;
    end
    foreach (tmp[i]) gen_q.push_back(tmp[i]);
  endfunction

  function automatic void add_val();
    int unsigned k;
    k = $urandom_range(0, 3);
    case (k)
      0: push_dec(64'($urandom_range(0, 99)));
      1: push_dec({$urandom, $urandom});
      2: for (int i = 0; i < 21; i++) gen_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      default: push_dec(64'($urandom_range(0, 9999)));
    endcase
  endfunction

  task automatic gen_random(output int mode);
    string junk;
    int unsigned nlines, n;
    junk = "0123456789-x: ";
    gen_q.delete();
    nlines = $urandom_range(0, 9);
    for (int l = 0; l < int'(nlines); l++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, 5);
        repeat (n) gen_q.push_back(u8'(junk[$urandom_range(0, junk.len() - 1)]));
      end else begin
        add_val(); gen_q.push_back(8'h2d); add_val();
      end
      if ($urandom_range(0, 3) == 0) gen_q.push_back(8'h0d);
      gen_q.push_back(8'h0a);
    end
    mode = int'($urandom_range(0, 2));
    if (mode == 2 && nlines == 0) mode = 0;
    if (mode == 0) begin
      if ($urandom_range(0, 1) == 1) gen_q.push_back(8'h0d);
      gen_q.push_back(8'h0a);
    end else if (mode == 1 && $urandom_range(0, 1) == 1) begin
      add_val();
      if ($urandom_range(0, 1) == 1) gen_q.push_back(8'h2d);
    end
  endtask

  // Called positioned at a negedge; returns positioned at a later negedge.
  task automatic send_byte(input u8 c, input bit with_eof, input bit is_trig, output bit ok);
    int unsigned gap;
    ok = 1'b0;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clock);
    char_in = c; char_valid_in = 1'b1; eof_in = with_eof;
    for (int t = 0; t < 50; t++) begin
      if (char_ready_out) begin
        if (is_trig) trig_cyc = cyc + 1;
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    char_valid_in = 1'b0; eof_in = 1'b0;
  endtask

  task automatic wait_done(input int start_done);
    int t;
    t = 0;
    while (done_cnt == start_done && t < 100) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (done_cnt == start_done) begin
      n_fail++;
      $display("FAIL done_timeout: stream_done_out=0 after %0d cycles, required a pulse", t);
    end
  endtask

  task automatic post_done_probe();
    for (int k = 0; k < 4; k++) begin
      char_in = (k == 3) ? 8'h0a : 8'h31 + 8'(k);
      char_valid_in = 1'b1;
      eof_in = (k == 2);
      check("ready_after_done", 128'(char_ready_out), 128'(0));
      @(negedge clock);
    end
    char_valid_in = 1'b0; eof_in = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // mode 0: blank line inside gen_q, 1: eof pulse after bytes, 2: eof with last byte
  task automatic run_episode(input int mode);
    int term_idx, last, start_done;
    bit ok;
    @(negedge clock);
    reset = 1'b0; char_valid_in = 1'b0; eof_in = 1'b0;
    #1;
    check_reset();
    exp_q.delete(); last_dv = -1; trig_cyc = -1;
    model(mode != 0, term_idx);
    @(negedge clock);
    reset = 1'b1;
    start_done = done_cnt;
    last = gen_q.size() - 1;
    ok = 1'b1;
    for (int i = 0; i <= last; i++) begin
      if (term_idx >= 0 && i > term_idx) break;
      send_byte(gen_q[i], (mode == 2) && (i == last),
                (i == term_idx) || ((mode == 2) && (i == last)), ok);
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL ready_timeout: byte %0d not accepted, char_ready_out=0 required 1", i);
        break;
      end
    end
    if (ok && mode == 1) begin
      eof_in = 1'b1; trig_cyc = cyc + 1;
      @(negedge clock);
      eof_in = 1'b0;
    end
    wait_done(start_done);
    post_done_probe();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    row_t r;
    logic prev_done;
    int   exp_cyc;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_done = 1'b0;
      end else begin
        if (data_valid_out) begin
          last_dv = cyc;
          check("write_not_with_done", 128'(stream_done_out), 128'(0));
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: addr %0d written, required no write", addr_out);
          end else begin
            r = exp_q.pop_front();
            check("row_addr", 128'(addr_out), 128'(r.addr));
            check("row_even", even_data_out, r.even);
            check("row_odd",  odd_data_out, r.odd);
          end
        end
        if (stream_done_out) begin
          exp_cyc = (last_dv >= trig_cyc) ? last_dv + 1 : trig_cyc;
          check("done_single_cycle", 128'(prev_done), 128'(0));
          check("tuple_count", 128'(tuple_count_out), 128'(exp_count));
          check("parse_error", 128'(parse_error_out), 128'(exp_err));
          check("rows_outstanding", 128'(exp_q.size()), 128'(0));
          check("done_latency", 128'(cyc), 128'(exp_cyc));
          done_cnt++;
        end
        prev_done = stream_done_out;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : driver
    int mode, term;
    bit ok;

    gen_q.delete(); add_str("3-5\n10-14\n\n"); run_episode(0);
    gen_q.delete(); add_str("3-5\n10-14\n16-20\n\n"); run_episode(0);
    gen_q.delete(); add_str("20-12\n"); run_episode(1);
    gen_q.delete(); add_str("20-12\n"); run_episode(2);
    gen_q.delete(); add_str("4x-9\n7-8\n1-1\n\n"); run_episode(0);
    gen_q.delete();
    add_str("281474976710655-281474976710656\015\n123456789012345678901-5\015\n\015\n");
    run_episode(0);
    gen_q.delete(); add_str("7-8\n1-2\n3-"); run_episode(1);

    // reset asserted mid-line, between clock edges
    gen_q.delete(); add_str("1-2\n3-4\nx\n12-3");
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset();
    exp_q.delete(); last_dv = -1; trig_cyc = -1;
    model(1'b0, term);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < gen_q.size(); i++) begin
      send_byte(gen_q[i], 1'b0, 1'b0, ok);
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL ready_timeout: byte %0d not accepted, char_ready_out=0 required 1", i);
        break;
      end
    end
    repeat (2) @(negedge clock);
    check("pre_reset_error", 128'(parse_error_out), 128'(exp_err));
    check("pre_reset_count", 128'(tuple_count_out), 128'(exp_count));
    check("pre_reset_addr",  128'(addr_out), 128'(exp_count / 2));
    #2;
    reset = 1'b0;
    #1;
    check_reset();
    gen_q.delete(); add_str("1-2\n5-6\n\n"); run_episode(0);

    // enough rows to wrap the 3-bit row address
    gen_q.delete();
    for (int k = 0; k < 19; k++) begin
      push_dec(64'(100 - k)); gen_q.push_back(8'h2d); push_dec(64'(k * 7));
      gen_q.push_back(8'h0a);
    end
    gen_q.push_back(8'h0a);
    run_episode(0);

    repeat (30) begin
      gen_random(mode);
      run_episode(mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
